// File: rtl/seq_divider_if.sv
// Requester/responder handshake bundle for the shared sequential divider.
//   start        requester -> divider  request pulse (or level) to load operands
//   dividend     requester -> divider  numerator, sampled on the accepting edge
//   divisor      requester -> divider  denominator, sampled on the accepting edge
//   busy         divider -> requester  high while iterating
//   ready        divider -> requester  one-cycle result-valid pulse
//   quotient     divider -> requester  held until the next accepted start
//   remainder    divider -> requester  held like quotient
//   div_by_zero  divider -> requester  sampled divisor was zero, held like quotient
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, ready, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, ready, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Shared multi-cycle unsigned divider, restoring radix-2, one quotient bit per clock.
// A request accepted in IDLE or DONE runs WIDTH iterations; the result registers update on the
// last iteration edge and ready pulses for the following cycle.
//   clk   clock, rising edge
//   rst   synchronous, active-high reset; abandons any division in flight
//   bus   seq_divider_if slave modport (start/operands in, busy/ready/results out)
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] r_q;       // partial remainder; never exceeds WIDTH bits
  logic [WIDTH-1:0] q_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             ready_q;
  logic             dz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   r_shift;   // extra bit carries the shifted-out MSB for the trial
  logic             fits;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    fits    = r_shift >= {1'b0, d_q};
    // After a successful trial the difference is below the divisor, and with a zero divisor
    // r_shift only ever holds a prefix of the dividend, so the top bit is always clear here.
    r_next  = fits ? WIDTH'(r_shift - {1'b0, d_q}) : r_shift[WIDTH-1:0];
    q_next  = {q_q[WIDTH-2:0], fits};
    accept  = bus.start && ((state_q == StIdle) || (state_q == StDone));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (accept) begin
        q_q     <= bus.dividend;
        d_q     <= bus.divisor;
        r_q     <= '0;
        cnt_q   <= CntW'(WIDTH - 1);
        busy_q  <= 1'b1;
        state_q <= StRun;
      end else begin
        unique case (state_q)
          StIdle: ;
          StRun: begin
            r_q   <= r_next;
            q_q   <= q_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              quotient_q  <= q_next;
              remainder_q <= r_next;
              dz_q        <= (d_q == '0);
              busy_q      <= 1'b0;
              ready_q     <= 1'b1;
              state_q     <= StDone;
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake cases plus random operand pairs
// compared against plain-arithmetic division.
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   mon_en;
  logic rst_at_edge;
  logic [2*W:0] prev_out;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned division, all-ones quotient and dividend remainder for b == 0.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endtask

  // Per-cycle protocol checks: busy/ready exclusive, results move only with ready or reset.
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_ready_excl", 64'(bus.busy & bus.ready), 64'd0);
      if (!bus.ready && !rst_at_edge)
        check("out_stable", 64'({bus.quotient, bus.remainder, bus.div_by_zero}),
              64'(prev_out));
    end
    prev_out = {bus.quotient, bus.remainder, bus.div_by_zero};
  end

  // Called at posedge+1 with the divider idle or in its ready cycle. Drives one request,
  // optionally pokes a stray start mid-run, and checks latency and results.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke, input bit hold);
    logic [W-1:0] eq, er;
    logic         edz;
    int           j;
    int           nbusy;
    bit           seen;
    model(a, b, eq, er, edz);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    j     = 0;
    nbusy = 0;
    seen  = 0;
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    while (!seen && j < int'(W) + 4) begin
      if (bus.ready) begin
        seen = 1;
      end else begin
        if (bus.busy) nbusy++;
        bus.start = (j == poke);
        if (j == poke) begin
          bus.dividend = 9;
          bus.divisor  = 3;
        end
        @(posedge clk); #1;
        j++;
      end
    end
    bus.start = 1'b0;
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(j), 64'(W));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(W));
    check({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
    check({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
    check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(edz));
    if (hold) begin
      @(posedge clk); #1;
      check({tag, "_ready_pulse"}, 64'(bus.ready), 64'd0);
      check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_q_held"}, 64'(bus.quotient), 64'(eq));
    end
  endtask

  initial begin
    int ready_cnt;
    logic [W-1:0] a, b;
    n_tests      = 0;
    n_fail       = 0;
    mon_en       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    rst    = 1'b0;
    mon_en = 1;
    @(posedge clk); #1;

    run_div("d1000_7", 16'd1000, 16'd7, -1, 1);
    run_div("d65535_1", 16'd65535, 16'd1, -1, 1);
    run_div("d0_9", 16'd0, 16'd9, -1, 1);
    run_div("d5_0", 16'd5, 16'd0, -1, 1);
    run_div("d6_3", 16'd6, 16'd3, -1, 1);
    run_div("ignore_start", 16'd21600, 16'd3600, 5, 1);
    run_div("b2b_100_10", 16'd100, 16'd10, -1, 0);
    run_div("b2b_99_10", 16'd99, 16'd10, -1, 1);

    // Reset in the middle of 1000/7: no result, outputs cleared.
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd0);
    check("midrst_quotient", 64'(bus.quotient), 64'd0);
    check("midrst_remainder", 64'(bus.remainder), 64'd0);
    check("midrst_dz", 64'(bus.div_by_zero), 64'd0);
    rst       = 1'b0;
    ready_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ready) ready_cnt++;
    end
    check("midrst_no_ready", 64'(ready_cnt), 64'd0);
    run_div("d12_5", 16'd12, 16'd5, -1, 1);

    for (int i = 0; i < 2000; i++) begin
      a = (($urandom_range(0, 3)) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom) >> $urandom_range(0, 15);
        3:       b = a;
        default: b = W'($urandom);
      endcase
      run_div("rand", a, b, -1, (i % 50) == 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule
